// File: rtl/display_multiplexado_if.sv
// rtl/display_multiplexado_if.sv - control and pin bundle for the multiplexed display driver
interface display_multiplexado_if #(
    parameter int N_DIGITOS = 4
);
    logic                   carregar;
    logic [4*N_DIGITOS-1:0] codigos;
    logic [N_DIGITOS-1:0]   pontos;
    logic [N_DIGITOS-1:0]   pisca;
    logic                   supressao_zeros;
    logic [6:0]             segmentos;
    logic                   ponto;
    logic [N_DIGITOS-1:0]   anodos;
    logic                   fim_quadro;

    modport master (
        output carregar, codigos, pontos, pisca, supressao_zeros,
        input  segmentos, ponto, anodos, fim_quadro
    );

    modport slave (
        input  carregar, codigos, pontos, pisca, supressao_zeros,
        output segmentos, ponto, anodos, fim_quadro
    );
endinterface

// File: rtl/display_multiplexado.sv
// rtl/display_multiplexado.sv - time-multiplexed N-digit hex 7-segment driver
module display_multiplexado #(
    parameter int N_DIGITOS         = 4,
    parameter int DIV_VARREDURA     = 50000,
    parameter int PISCA_QUADROS     = 64,
    parameter int SEG_ATIVO_BAIXO   = 1,
    parameter int ANODO_ATIVO_BAIXO = 1
) (
    input  logic clk,
    input  logic rst,
    display_multiplexado_if.slave bus
);
    localparam int IW = (N_DIGITOS > 1) ? $clog2(N_DIGITOS) : 1;
    localparam int PW = (DIV_VARREDURA > 1) ? $clog2(DIV_VARREDURA) : 1;
    localparam int FW = (PISCA_QUADROS > 1) ? $clog2(PISCA_QUADROS) : 1;
    localparam logic [6:0]           SEG_INV = (SEG_ATIVO_BAIXO != 0) ? 7'h7F : 7'h00;
    localparam logic                 PT_INV  = (SEG_ATIVO_BAIXO != 0);
    localparam logic [N_DIGITOS-1:0] AN_INV  = (ANODO_ATIVO_BAIXO != 0) ? '1 : '0;

    logic [4*N_DIGITOS-1:0] cod_q;
    logic [N_DIGITOS-1:0]   pt_q;
    logic [PW-1:0]          pre_q;
    logic [IW-1:0]          idx_q;
    logic [FW-1:0]          quad_q;
    logic                   fase_q;
    logic [6:0]             seg_q;
    logic                   ponto_q;
    logic [N_DIGITOS-1:0]   an_q;
    logic                   fim_q;

    logic fim_pre, fim_dig, fim_frame, fim_pisca;
    assign fim_pre   = (pre_q == PW'(DIV_VARREDURA - 1));
    assign fim_dig   = (idx_q == IW'(N_DIGITOS - 1));
    assign fim_frame = fim_pre && fim_dig;
    assign fim_pisca = (quad_q == FW'(PISCA_QUADROS - 1));

    function automatic logic [6:0] decod(input logic [3:0] c);
        case (c)
            4'h0: decod = 7'b0111111;
            4'h1: decod = 7'b0000110;
            4'h2: decod = 7'b1011011;
            4'h3: decod = 7'b1001111;
            4'h4: decod = 7'b1100110;
            4'h5: decod = 7'b1101101;
            4'h6: decod = 7'b1111101;
            4'h7: decod = 7'b0000111;
            4'h8: decod = 7'b1111111;
            4'h9: decod = 7'b1101111;
            4'hA: decod = 7'b1110111;
            4'hB: decod = 7'b1111100;
            4'hC: decod = 7'b0111001;
            4'hD: decod = 7'b1011110;
            4'hE: decod = 7'b1111001;
            default: decod = 7'b1110001;
        endcase
    endfunction

    logic [3:0]           cod_sel;
    logic                 pt_sel, pisca_sel, zeros_sel, acima;
    logic [N_DIGITOS-1:0] an_sel;
    logic [6:0]           seg_d;
    logic                 ponto_d;

    always_comb begin
        cod_sel   = '0;
        pt_sel    = 1'b0;
        pisca_sel = 1'b0;
        zeros_sel = 1'b0;
        an_sel    = '0;
        acima     = 1'b1;
        // Walk from the most significant digit down so "acima" means: this digit and all above are zero
        for (int i = N_DIGITOS - 1; i >= 0; i--) begin
            acima = acima && (cod_q[4*i +: 4] == 4'h0);
            if (idx_q == IW'(i)) begin
                cod_sel   = cod_q[4*i +: 4];
                pt_sel    = pt_q[i];
                pisca_sel = bus.pisca[i];
                zeros_sel = acima && (i != 0);
                an_sel[i] = 1'b1;
            end
        end
        seg_d   = decod(cod_sel);
        ponto_d = pt_sel;
        if (bus.supressao_zeros && zeros_sel)
            seg_d = 7'b0;
        if (pisca_sel && fase_q) begin
            seg_d   = 7'b0;
            ponto_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cod_q   <= '0;
            pt_q    <= '0;
            pre_q   <= '0;
            idx_q   <= '0;
            quad_q  <= '0;
            fase_q  <= 1'b0;
            seg_q   <= SEG_INV;
            ponto_q <= PT_INV;
            an_q    <= AN_INV;
            fim_q   <= 1'b0;
        end else begin
            if (bus.carregar) begin
                cod_q <= bus.codigos;
                pt_q  <= bus.pontos;
            end
            pre_q <= fim_pre ? '0 : pre_q + 1'b1;
            if (fim_pre)
                idx_q <= fim_dig ? '0 : idx_q + 1'b1;
            if (fim_frame) begin
                if (fim_pisca) begin
                    quad_q <= '0;
                    fase_q <= ~fase_q;
                end else begin
                    quad_q <= quad_q + 1'b1;
                end
            end
            fim_q   <= fim_frame;
            seg_q   <= seg_d ^ SEG_INV;
            ponto_q <= ponto_d ^ PT_INV;
            an_q    <= an_sel ^ AN_INV;
        end
    end

    assign bus.segmentos  = seg_q;
    assign bus.ponto      = ponto_q;
    assign bus.anodos     = an_q;
    assign bus.fim_quadro = fim_q;
endmodule

// File: tb/tb_display_multiplexado.sv
// tb/tb_display_multiplexado.sv - randomized and directed bench for display_multiplexado
module tb_display_multiplexado;
    localparam int N   = 4;
    localparam int DIV = 4;
    localparam int PQ  = 2;
    localparam int FR  = DIV * N;
    localparam logic [6:0] DEC [16] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
        7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
        7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
        7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001};

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic           carregar = 1'b0;
    logic [4*N-1:0] codigos  = '0;
    logic [N-1:0]   pontos   = '0;
    logic [N-1:0]   pisca    = '0;
    logic           sup      = 1'b0;

    display_multiplexado_if #(.N_DIGITOS(N)) bl ();
    display_multiplexado_if #(.N_DIGITOS(N)) bh ();

    assign bl.carregar = carregar;  assign bh.carregar = carregar;
    assign bl.codigos  = codigos;   assign bh.codigos  = codigos;
    assign bl.pontos   = pontos;    assign bh.pontos   = pontos;
    assign bl.pisca    = pisca;     assign bh.pisca    = pisca;
    assign bl.supressao_zeros = sup;
    assign bh.supressao_zeros = sup;

    display_multiplexado #(.N_DIGITOS(N), .DIV_VARREDURA(DIV), .PISCA_QUADROS(PQ),
        .SEG_ATIVO_BAIXO(1), .ANODO_ATIVO_BAIXO(1)) dut_lo (.clk(clk), .rst(rst), .bus(bl.slave));
    display_multiplexado #(.N_DIGITOS(N), .DIV_VARREDURA(DIV), .PISCA_QUADROS(PQ),
        .SEG_ATIVO_BAIXO(0), .ANODO_ATIVO_BAIXO(0)) dut_hi (.clk(clk), .rst(rst), .bus(bh.slave));

    int             m = 0;
    logic [4*N-1:0] sh_cod = '0;
    logic [N-1:0]   sh_pt  = '0;
    int             passed = 0;
    int             total  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h edges=%0d", tag, obs, exp, m);
    endtask

    // Expected outputs follow from the number of edges since reset and the loaded contents.
    task automatic step();
        int         idx;
        bit         blink, blank_z;
        logic [6:0] es, es_n;
        logic       ep, ep_n, ef;
        logic [N-1:0] ea, ea_n;
        idx     = (m / DIV) % N;
        blink   = pisca[idx] && (((m / FR) / PQ) % 2 == 1);
        blank_z = sup && (idx > 0);
        for (int j = idx; j < N; j++)
            if (sh_cod[4*j +: 4] != 4'h0) blank_z = 1'b0;
        es = DEC[sh_cod[4*idx +: 4]];
        ep = sh_pt[idx];
        if (blank_z) es = 7'b0;
        if (blink) begin es = 7'b0; ep = 1'b0; end
        ea = '0;
        ea[idx] = 1'b1;
        ef   = ((m + 1) % FR == 0);
        es_n = ~es;
        ep_n = ~ep;
        ea_n = ~ea;
        @(posedge clk);
        m++;
        if (carregar) begin
            sh_cod = codigos;
            sh_pt  = pontos;
        end
        #1;
        chk("lo_seg", bl.segmentos, es_n);
        chk("lo_pt",  bl.ponto,     ep_n);
        chk("lo_an",  bl.anodos,    ea_n);
        chk("lo_fim", bl.fim_quadro, ef);
        chk("hi_seg", bh.segmentos, es);
        chk("hi_pt",  bh.ponto,     ep);
        chk("hi_an",  bh.anodos,    ea);
        chk("hi_fim", bh.fim_quadro, ef);
    endtask

    task automatic do_reset(input string tag);
        #2 rst = 1'b1;
        #1;
        chk({tag, "_lo_seg"}, bl.segmentos, 7'h7F);
        chk({tag, "_lo_pt"},  bl.ponto,     1'b1);
        chk({tag, "_lo_an"},  bl.anodos,    4'hF);
        chk({tag, "_lo_fim"}, bl.fim_quadro, 1'b0);
        chk({tag, "_hi_seg"}, bh.segmentos, 7'h00);
        chk({tag, "_hi_pt"},  bh.ponto,     1'b0);
        chk({tag, "_hi_an"},  bh.anodos,    4'h0);
        chk({tag, "_hi_fim"}, bh.fim_quadro, 1'b0);
        @(negedge clk);
        rst    = 1'b0;
        m      = 0;
        sh_cod = '0;
        sh_pt  = '0;
    endtask

    initial begin
        #1;
        do_reset("rst0");

        // Basic scan of 1A2F
        carregar = 1'b1; codigos = 16'h1A2F; pontos = 4'b0000;
        step();
        carregar = 1'b0;
        step();
        chk("f_digit0_seg", bl.segmentos, 7'b0001110);
        chk("f_digit0_an",  bl.anodos,    4'b1110);
        for (int k = 0; k < 2 * FR; k++) step();

        // Leading-zero suppression
        sup = 1'b1; carregar = 1'b1; codigos = 16'h0050;
        step();
        carregar = 1'b0;
        for (int k = 0; k < FR; k++) step();
        carregar = 1'b1; codigos = 16'h0000;
        step();
        carregar = 1'b0;
        for (int k = 0; k < FR; k++) step();

        // All-8 with a decimal point on digit 2
        carregar = 1'b1; codigos = 16'h8888; pontos = 4'b0100;
        step();
        carregar = 1'b0;
        step();
        chk("all8_hi_seg", bh.segmentos, 7'b1111111);
        for (int k = 0; k < FR; k++) step();

        // Blink on digit 0 across several phases
        sup = 1'b0; pisca = 4'b0001; pontos = 4'b0001;
        carregar = 1'b1;
        step();
        carregar = 1'b0;
        for (int k = 0; k < 5 * FR; k++) step();

        // Load coincident with the frame wrap
        pisca = 4'b0000;
        for (int k = 0; k < FR && ((m + 1) % FR) != 0; k++) step();
        carregar = 1'b1; codigos = 16'h9876; pontos = 4'b0000;
        step();
        chk("wrap_load_fim", bh.fim_quadro, 1'b1);
        carregar = 1'b0;
        step();
        chk("wrap_load_seg6", bl.segmentos, 7'b0000010);

        // Reset in the middle of digit 2's slot
        for (int k = 0; k < FR && (m % FR) != 9; k++) step();
        do_reset("rst_mid");
        step();
        chk("post_rst_seg0", bl.segmentos, 7'b1000000);
        for (int k = 0; k < FR; k++) step();

        // Randomized traffic against the model
        for (int k = 0; k < 400; k++) begin
            carregar = ($urandom_range(0, 7) == 0);
            if (carregar) begin
                for (int d = 0; d < N; d++)
                    codigos[4*d +: 4] = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(0, 15));
                pontos = 4'($urandom);
            end
            if ($urandom_range(0, 31) == 0) pisca = 4'($urandom);
            if ($urandom_range(0, 15) == 0) sup = ~sup;
            if ($urandom_range(0, 199) == 0) do_reset("rst_rand");
            step();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/display_multiplexado.md
Name: display_multiplexado

Overview:
- Parametrised, time-multiplexed driver for N_DIGITOS common-segment 7-segment digits.
- Latches a packed vector of 4-bit hex codes on a load strobe and scans the digits one at a time with a one-hot digit select.
- Adds hex A-F decoding, decimal points, leading-zero suppression, per-digit blink and selectable output polarity.
- Sits between the vending-machine control/credit logic and the board display pins, replacing the single-digit decoder.

Parameters:
- N_DIGITOS, 4: number of digits scanned (≥1); digit 0 is least significant.
- DIV_VARREDURA, 50000: clk cycles each digit stays selected (≥1).
- PISCA_QUADROS, 64: complete scan frames per blink half-period (≥1).
- SEG_ATIVO_BAIXO, 1: 1 = segmentos and ponto are driven active-low.
- ANODO_ATIVO_BAIXO, 1: 1 = anodos are driven active-low.

Ports:
- clk  input  1  system clock; all state changes on posedge.
- rst  input  1  asynchronous reset, active-high.
- carregar  input  1  load strobe; samples codigos/pontos at the same posedge.
- codigos  input  4*N_DIGITOS  packed hex codes; bits [4i+3:4i] belong to digit i.
- pontos  input  N_DIGITOS  decimal point request per digit.
- pisca  input  N_DIGITOS  blink enable per digit.
- supressao_zeros  input  1  enables leading-zero blanking.
- segmentos  output  7  segment drive {g,f,e,d,c,b,a}, bit6 = g.
- ponto  output  1  decimal point drive for the selected digit.
- anodos  output  N_DIGITOS  one-hot digit select; bit i = digit i.
- fim_quadro  output  1  one-cycle pulse when the scan wraps from digit N_DIGITOS-1 to 0.

Behaviour:
- rst=1 clears all state immediately, without waiting for a clock edge:
  - shadow codes/points = 0, prescaler = 0, digit index = 0, frame counter = 0, blink phase = 0.
  - Outputs go to their inactive levels: segmentos all off, ponto off, anodos all off, fim_quadro = 0.
- Load: carregar=1 at a posedge copies codigos/pontos into the shadow registers. pisca and supressao_zeros are used live, not latched.
- Prescaler: counts 0..DIV_VARREDURA-1 and wraps.
  - On wrap, the digit index advances modulo N_DIGITOS.
  - With DIV_VARREDURA=1 the index advances every cycle.
- Frame wrap (index N_DIGITOS-1 → 0):
  - fim_quadro=1 for exactly that cycle.
  - Frame counter increments; on reaching PISCA_QUADROS it resets to 0 and the blink phase toggles.
- Outputs are registered with 1-cycle latency: outputs at cycle t+1 reflect the index and shadow contents at cycle t. Exactly one anodos bit is active after the first post-reset edge.
- Decode, active-high logic level before polarity inversion:
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111
  - 8=1111111, 9=1101111, A=1110111, b=1111100, C=0111001, d=1011110, E=1111001, F=1110001
  - All 16 codes are defined; there is no latch or hold behaviour for any code.
- Leading-zero suppression: digit i (i>0) is blanked when all of the following hold:
  - supressao_zeros=1;
  - its code is 0;
  - every digit j>i also has code 0.
  - Digit 0 is never suppressed.
  - A suppressed digit still drives ponto from its shadow point bit.
- Blink: when pisca[i]=1 and blink phase=1, digit i forces segmentos off and ponto off. Its anodo remains active, so scan timing is unchanged.
- Polarity: SEG_ATIVO_BAIXO inverts segmentos and ponto; ANODO_ATIVO_BAIXO inverts anodos. Inactive levels follow the same inversion, including during reset.
- Simultaneous events:
  - carregar on a prescaler or frame wrap: both actions take effect; the load is not delayed.
  - rst asserted mid-frame: scan restarts at digit 0 with the prescaler at 0 after release.

Test Plan:
- N=4, DIV=4, SEG/ANODO low: after reset release, load codigos=16'h1A2F with pontos=0 → anodos cycles 1110,1101,1011,0111, each held 4 clocks. segmentos = ~0001110 (F), ~1011011 (2), ~1110111 (A), ~0000110 (1), each 1 cycle after its select. fim_quadro pulses once per 16 clocks.
- Suppression: load 16'h0050, supressao_zeros=1 → digits 3 and 2 blank, digit 1 shows ~1101101 (5), digit 0 shows ~0111111 (0). Load 16'h0000 → only digit 0 lit, showing 0.
- Blink, PISCA_QUADROS=2: pisca=4'b0001 → digit 0 segments alternate shown/blank every 2 frames (32 clocks). Digits 1-3 are unaffected and anodos timing is unchanged.
- Reset mid-scan: assert rst asynchronously at digit 2, mid-slot → outputs go inactive the same cycle with no clock edge needed. After release, scan restarts at digit 0 with a full 4-clock slot and shadow codes = 0.
- Load coincident with frame wrap: carregar with 16'h9876 on the wrap cycle → fim_quadro=1 and the next digit-0 slot shows ~1111101 (6).
- Points and polarity: pontos=4'b0100, SEG_ATIVO_BAIXO=0 → ponto=1 only during digit 2's slot. An all-8 pattern gives segmentos=1111111.
